// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bus bundle between ram_arbiter and its environment: the three SRAM
// requesters (flash loader, CPU chip-select path, diagnostics engine) and
// the sram64k array port.
//   slave  : arbiter view (requests/ram_rdata in; acks, data, SRAM drive out)
//   master : environment view (the mirror image of slave)
// Signals:
//   load_done, halt                 loader finished / diagnostics holds CPU
//   cpu_req/we/addr/wdata           CPU request (level per access)
//   cpu_rdata, cpu_wait             CPU read data and RWAIT
//   flash_req/we/addr/wdata/ack     flash loader request and ack pulse
//   diag_req/we/addr/wdata/ack      diagnostics request and ack pulse
//   rd_data                         flash/diag read data
//   ram_addr/wdata/cs/we, ram_rdata SRAM port
interface ram_arbiter_if;
  logic        load_done;
  logic        halt;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic        flash_req;
  logic        flash_we;
  logic [15:0] flash_addr;
  logic [7:0]  flash_wdata;
  logic        flash_ack;
  logic        diag_req;
  logic        diag_we;
  logic [15:0] diag_addr;
  logic [7:0]  diag_wdata;
  logic        diag_ack;
  logic [7:0]  rd_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_cs;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  modport slave (
    input  load_done, halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           flash_req, flash_we, flash_addr, flash_wdata,
           diag_req, diag_we, diag_addr, diag_wdata, ram_rdata,
    output cpu_rdata, cpu_wait, flash_ack, diag_ack, rd_data,
           ram_addr, ram_wdata, ram_cs, ram_we
  );

  modport master (
    output load_done, halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           flash_req, flash_we, flash_addr, flash_wdata,
           diag_req, diag_we, diag_addr, diag_wdata, ram_rdata,
    input  cpu_rdata, cpu_wait, flash_ack, diag_ack, rd_data,
           ram_addr, ram_wdata, ram_cs, ram_we
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Clocked arbiter/sequencer for the single-port 64 KB SRAM. After reset only
// the flash loader is served (LOAD); once load_done is seen with no flash
// access in flight the block enters run mode and arbitrates CPU and
// diagnostics accesses, one SRAM cycle each (IDLE -> ACCESS -> ACK).
// Ports:
//   clk    48 MHz oscillator clock, rising edge
//   reset  synchronous, active high
//   bus    ram_arbiter_if.slave (requesters + SRAM port)
// Parameter:
//   WR_SETTLE  cycles cpu_req must be high before a CPU write is issued (1..15)
module ram_arbiter #(
  parameter int unsigned WR_SETTLE = 3
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  localparam logic [3:0] SETTLE_C = 4'(WR_SETTLE);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FLASH = 2'd1,
    OWN_CPU   = 2'd2,
    OWN_DIAG  = 2'd3
  } owner_t;

  state_t     state_r;
  state_t     state_s;
  owner_t     grant_s;
  owner_t     owner_r;
  logic       we_r;
  logic       run_r;
  logic       run_set_s;
  logic       cpu_prev_r;
  logic       cpu_pend_r;
  logic       cpu_fired_r;
  logic [3:0] settle_r;
  logic       after_cpu_r;
  logic       flash_ack_d_r;
  logic       diag_ack_d_r;
  logic       cpu_pend_s;
  logic       flash_pend_s;
  logic       diag_pend_s;

  // A pending CPU access is cancelled the moment cpu_req drops.
  assign cpu_pend_s   = cpu_pend_r & bus.cpu_req;
  // Requesters may keep req high for up to one cycle after their ack, so the
  // ack cycle and the one after it are not treated as a new request.
  assign flash_pend_s = bus.flash_req & ~bus.flash_ack & ~flash_ack_d_r;
  assign diag_pend_s  = bus.diag_req & ~bus.diag_ack & ~diag_ack_d_r;

  // Arbitration and next-state decision.
  always_comb begin
    state_s   = state_r;
    grant_s   = OWN_NONE;
    run_set_s = 1'b0;
    case (state_r)
      LOAD: begin
        // Only reachable between flash accesses, so nothing is in flight here.
        if (bus.load_done) begin
          run_set_s = 1'b1;
          state_s   = IDLE;
        end else if (flash_pend_s) begin
          grant_s = OWN_FLASH;
          state_s = ACCESS;
        end else begin
          state_s = LOAD;
        end
      end
      IDLE: begin
        // CPU first, except directly after a CPU access when diag is waiting.
        if (cpu_pend_s && !(diag_pend_s && after_cpu_r)) begin
          grant_s = OWN_CPU;
          state_s = ACCESS;
        end else if (diag_pend_s) begin
          grant_s = OWN_DIAG;
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s = ACK;
      end
      ACK: begin
        if (run_r) begin
          state_s = IDLE;
        end else begin
          state_s = LOAD;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // CPU request tracking: exactly one pending access per cpu_req assertion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_prev_r  <= 1'b0;
      cpu_pend_r  <= 1'b0;
      cpu_fired_r <= 1'b0;
      settle_r    <= 4'd0;
    end else begin
      cpu_prev_r <= bus.cpu_req;
      if (!bus.cpu_req) begin
        settle_r    <= 4'd0;
        cpu_pend_r  <= 1'b0;
        cpu_fired_r <= 1'b0;
      end else if (grant_s == OWN_CPU) begin
        cpu_pend_r <= 1'b0;
      end else if (run_r && !cpu_fired_r) begin
        if (!bus.cpu_we) begin
          // Reads go pending on the rising edge of cpu_req.
          if (!cpu_prev_r) begin
            cpu_pend_r  <= 1'b1;
            cpu_fired_r <= 1'b1;
          end
        end else if (settle_r == SETTLE_C) begin
          // Writes wait for the CPU data bus to settle.
          cpu_pend_r  <= 1'b1;
          cpu_fired_r <= 1'b1;
        end else begin
          settle_r <= settle_r + 4'd1;
        end
      end
    end
  end

  // Registered SRAM drive, completion capture, acks and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r         <= 1'b0;
      owner_r       <= OWN_NONE;
      we_r          <= 1'b0;
      after_cpu_r   <= 1'b0;
      flash_ack_d_r <= 1'b0;
      diag_ack_d_r  <= 1'b0;
      bus.ram_cs    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= 16'h0000;
      bus.ram_wdata <= 8'h00;
      bus.cpu_rdata <= 8'h00;
      bus.rd_data   <= 8'h00;
      bus.flash_ack <= 1'b0;
      bus.diag_ack  <= 1'b0;
      bus.cpu_wait  <= 1'b1;
    end else begin
      if (run_set_s) begin
        run_r <= 1'b1;
      end
      bus.cpu_wait  <= ~run_r | bus.halt;
      flash_ack_d_r <= bus.flash_ack;
      diag_ack_d_r  <= bus.diag_ack;
      after_cpu_r   <= (state_r == ACK) && (owner_r == OWN_CPU);
      bus.flash_ack <= 1'b0;
      bus.diag_ack  <= 1'b0;
      // ram_cs/ram_we are high only during the single ACCESS cycle.
      bus.ram_cs    <= (grant_s != OWN_NONE);
      bus.ram_we    <= 1'b0;
      case (grant_s)
        OWN_FLASH: begin
          owner_r       <= OWN_FLASH;
          we_r          <= bus.flash_we;
          bus.ram_we    <= bus.flash_we;
          bus.ram_addr  <= bus.flash_addr;
          bus.ram_wdata <= bus.flash_wdata;
        end
        OWN_CPU: begin
          owner_r       <= OWN_CPU;
          we_r          <= bus.cpu_we;
          bus.ram_we    <= bus.cpu_we;
          bus.ram_addr  <= bus.cpu_addr;
          bus.ram_wdata <= bus.cpu_wdata;
        end
        OWN_DIAG: begin
          owner_r       <= OWN_DIAG;
          we_r          <= bus.diag_we;
          bus.ram_we    <= bus.diag_we;
          bus.ram_addr  <= bus.diag_addr;
          bus.ram_wdata <= bus.diag_wdata;
        end
        default: begin
          owner_r <= owner_r;
          we_r    <= we_r;
        end
      endcase
      // ram_rdata is valid in ACK, one cycle after ram_cs.
      if (state_r == ACK) begin
        case (owner_r)
          OWN_FLASH: begin
            bus.flash_ack <= 1'b1;
            if (!we_r) begin
              bus.rd_data <= bus.ram_rdata;
            end
          end
          OWN_CPU: begin
            if (!we_r) begin
              bus.cpu_rdata <= bus.ram_rdata;
            end
          end
          OWN_DIAG: begin
            bus.diag_ack <= 1'b1;
            if (!we_r) begin
              bus.rd_data <= bus.ram_rdata;
            end
          end
          default: begin
            bus.rd_data <= bus.rd_data;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. A behavioural SRAM array stands in
// for sram64k; ref_mem holds the contents the bench expects from the writes
// it issued, and expected timings come from the documented latencies.
module tb_ram_arbiter;
  localparam int WR_SETTLE = 3;
  // Cycle counts measured from the cycle the request is driven.
  localparam int LAT_ACK      = 3;              // flash/diag ack
  localparam int LAT_CPU_RD   = 4;              // cpu_rdata updated
  localparam int CS_CPU_RD    = 2;              // ram_cs for a CPU read
  localparam int CS_CPU_WR    = WR_SETTLE + 2;  // ram_cs for a CPU write

  logic clk = 1'b0;
  logic reset;
  ram_arbiter_if bus ();

  ram_arbiter #(.WR_SETTLE(WR_SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit [7:0]   sram    [0:65535];
  bit [7:0]   ref_mem [0:65535];
  logic [7:0] exp_cpu_rdata;
  logic [7:0] exp_rd_data;
  int checks = 0;
  int errors = 0;
  int cs_count = 0;

  // SRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_cs === 1'b1) begin
      if (bus.ram_we === 1'b1) sram[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= sram[bus.ram_addr];
    end
  end

  // Count SRAM cycles.
  always @(negedge clk) begin
    if (bus.ram_cs === 1'b1) cs_count <= cs_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.ram_cs !== 1'b0) begin errors++; $display("FAIL rst_ram_cs got %0h want 0", bus.ram_cs); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %0h want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h0000) begin errors++; $display("FAIL rst_ram_addr got %0h want 0", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 8'h00) begin errors++; $display("FAIL rst_ram_wdata got %0h want 0", bus.ram_wdata); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_cpu_rdata got %0h want 0", bus.cpu_rdata); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %0h want 0", bus.rd_data); end
    checks++; if (bus.flash_ack !== 1'b0) begin errors++; $display("FAIL rst_flash_ack got %0h want 0", bus.flash_ack); end
    checks++; if (bus.diag_ack !== 1'b0) begin errors++; $display("FAIL rst_diag_ack got %0h want 0", bus.diag_ack); end
    checks++; if (bus.cpu_wait !== 1'b1) begin errors++; $display("FAIL rst_cpu_wait got %0h want 1", bus.cpu_wait); end
    reset = 1'b0;
    exp_cpu_rdata = 8'h00;
    exp_rd_data = 8'h00;
    step();
  endtask

  task automatic test_boot();
    int cs0;
    int lat;
    cs0 = cs_count;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_req = i[0];
      bus.cpu_we = 1'b0;
      bus.flash_req = 1'b1;
      bus.flash_we = 1'b1;
      bus.flash_addr = 16'(i);
      bus.flash_wdata = 8'hA0 + 8'(i);
      ref_mem[i] = 8'hA0 + 8'(i);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        step();
        if (bus.flash_ack === 1'b1) begin
          lat = n;
          break;
        end
      end
      bus.flash_req = 1'b0;
      checks++; if (lat != LAT_ACK) begin errors++; $display("FAIL boot_flash_ack_latency got %0d want %0d", lat, LAT_ACK); end
      step();
      step();
    end
    bus.cpu_req = 1'b0;
    step();
    checks++; if (cs_count - cs0 != 4) begin errors++; $display("FAIL boot_sram_cycles got %0d want 4", cs_count - cs0); end
    checks++; if (sram[3] !== 8'hA3) begin errors++; $display("FAIL boot_sram_word3 got %0h want a3", sram[3]); end
    bus.load_done = 1'b1;
    step();
    checks++; if (bus.cpu_wait !== 1'b1) begin errors++; $display("FAIL boot_wait_enter_idle got %0h want 1", bus.cpu_wait); end
    step();
    checks++; if (bus.cpu_wait !== 1'b0) begin errors++; $display("FAIL boot_wait_fall got %0h want 0", bus.cpu_wait); end
  endtask

  task automatic test_cpu_read(input logic [15:0] addr, input int hold);
    int cs0;
    int cs_cyc;
    cs0 = cs_count;
    cs_cyc = -1;
    bus.cpu_addr = addr;
    bus.cpu_we = 1'b0;
    bus.cpu_req = 1'b1;
    for (int n = 1; n <= hold; n++) begin
      step();
      if (bus.ram_cs === 1'b1 && cs_cyc < 0) cs_cyc = n;
      if (n == LAT_CPU_RD - 1) begin
        checks++; if (bus.cpu_rdata !== exp_cpu_rdata) begin errors++; $display("FAIL cpu_rd_early got %0h want %0h", bus.cpu_rdata, exp_cpu_rdata); end
      end
      if (n == LAT_CPU_RD) begin
        checks++; if (bus.cpu_rdata !== ref_mem[addr]) begin errors++; $display("FAIL cpu_rd_data @%0h got %0h want %0h", addr, bus.cpu_rdata, ref_mem[addr]); end
      end
    end
    exp_cpu_rdata = ref_mem[addr];
    bus.cpu_req = 1'b0;
    checks++; if (cs_cyc != CS_CPU_RD) begin errors++; $display("FAIL cpu_rd_cs_cycle got %0d want %0d", cs_cyc, CS_CPU_RD); end
    checks++; if (cs_count - cs0 != 1) begin errors++; $display("FAIL cpu_rd_single got %0d want 1", cs_count - cs0); end
    step();
    step();
  endtask

  task automatic test_cpu_write(input logic [15:0] addr, input logic [7:0] data);
    int cs0;
    int cs_cyc;
    logic cs_we;
    logic [15:0] cs_addr;
    cs0 = cs_count;
    cs_cyc = -1;
    cs_we = 1'b0;
    cs_addr = 16'h0000;
    bus.cpu_addr = addr;
    bus.cpu_wdata = data;
    bus.cpu_we = 1'b1;
    bus.cpu_req = 1'b1;
    for (int n = 1; n <= CS_CPU_WR + 4; n++) begin
      step();
      if (bus.ram_cs === 1'b1 && cs_cyc < 0) begin
        cs_cyc = n;
        cs_we = bus.ram_we;
        cs_addr = bus.ram_addr;
      end
    end
    bus.cpu_req = 1'b0;
    ref_mem[addr] = data;
    checks++; if (cs_cyc != CS_CPU_WR) begin errors++; $display("FAIL cpu_wr_cs_cycle got %0d want %0d", cs_cyc, CS_CPU_WR); end
    checks++; if (cs_we !== 1'b1 || cs_addr !== addr) begin errors++; $display("FAIL cpu_wr_cmd got we=%0h addr=%0h want we=1 addr=%0h", cs_we, cs_addr, addr); end
    checks++; if (cs_count - cs0 != 1) begin errors++; $display("FAIL cpu_wr_single got %0d want 1", cs_count - cs0); end
    checks++; if (sram[addr] !== data) begin errors++; $display("FAIL cpu_wr_data @%0h got %0h want %0h", addr, sram[addr], data); end
    step();
    step();
  endtask

  task automatic test_cpu_write_cancel();
    int cs0;
    cs0 = cs_count;
    bus.cpu_addr = 16'h8001;
    bus.cpu_wdata = 8'h66;
    bus.cpu_we = 1'b1;
    bus.cpu_req = 1'b1;
    step();
    step();
    bus.cpu_req = 1'b0;
    for (int n = 0; n < 8; n++) step();
    checks++; if (cs_count - cs0 != 0) begin errors++; $display("FAIL cpu_wr_cancel_cycles got %0d want 0", cs_count - cs0); end
    checks++; if (sram[16'h8001] !== ref_mem[16'h8001]) begin errors++; $display("FAIL cpu_wr_cancel_data got %0h want %0h", sram[16'h8001], ref_mem[16'h8001]); end
  endtask

  task automatic test_diag(input logic we, input logic [15:0] addr, input logic [7:0] data);
    int lat;
    lat = 0;
    bus.diag_addr = addr;
    bus.diag_wdata = data;
    bus.diag_we = we;
    bus.diag_req = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (bus.diag_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    bus.diag_req = 1'b0;
    if (we) ref_mem[addr] = data;
    else exp_rd_data = ref_mem[addr];
    checks++; if (lat != LAT_ACK) begin errors++; $display("FAIL diag_ack_latency got %0d want %0d", lat, LAT_ACK); end
    checks++; if (bus.rd_data !== exp_rd_data) begin errors++; $display("FAIL diag_rd_data @%0h got %0h want %0h", addr, bus.rd_data, exp_rd_data); end
    checks++; if (sram[addr] !== ref_mem[addr]) begin errors++; $display("FAIL diag_sram @%0h got %0h want %0h", addr, sram[addr], ref_mem[addr]); end
    step();
    step();
  endtask

  task automatic test_contention();
    int lat;
    lat = 0;
    bus.cpu_addr = 16'h0003;
    bus.cpu_we = 1'b0;
    bus.cpu_req = 1'b1;
    step();
    bus.diag_addr = 16'h0001;
    bus.diag_we = 1'b0;
    bus.diag_req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 1) begin
        checks++; if (bus.ram_cs !== 1'b1 || bus.ram_addr !== 16'h0003) begin errors++; $display("FAIL cont_cpu_first got cs=%0h addr=%0h want cs=1 addr=3", bus.ram_cs, bus.ram_addr); end
      end
      if (n == 3) begin
        checks++; if (bus.cpu_rdata !== ref_mem[3]) begin errors++; $display("FAIL cont_cpu_rdata got %0h want %0h", bus.cpu_rdata, ref_mem[3]); end
      end
      if (bus.diag_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    bus.diag_req = 1'b0;
    bus.cpu_req = 1'b0;
    exp_cpu_rdata = ref_mem[3];
    exp_rd_data = ref_mem[1];
    checks++; if (lat != 6) begin errors++; $display("FAIL cont_diag_latency got %0d want 6", lat); end
    checks++; if (bus.rd_data !== exp_rd_data) begin errors++; $display("FAIL cont_rd_data got %0h want %0h", bus.rd_data, exp_rd_data); end
    step();
    step();
  endtask

  task automatic test_halt();
    bus.halt = 1'b1;
    step();
    checks++; if (bus.cpu_wait !== 1'b1) begin errors++; $display("FAIL halt_wait_rise got %0h want 1", bus.cpu_wait); end
    test_diag(1'b1, 16'h1234, 8'h77);
    checks++; if (bus.cpu_wait !== 1'b1) begin errors++; $display("FAIL halt_wait_held got %0h want 1", bus.cpu_wait); end
    bus.halt = 1'b0;
    step();
    checks++; if (bus.cpu_wait !== 1'b0) begin errors++; $display("FAIL halt_wait_fall got %0h want 0", bus.cpu_wait); end
    test_cpu_read(16'h1234, 6);
  endtask

  task automatic test_random();
    int kind;
    logic [15:0] addr;
    logic [7:0] data;
    for (int k = 0; k < 24; k++) begin
      kind = int'($urandom_range(0, 3));
      addr = 16'h4000 + 16'($urandom_range(0, 7));
      data = 8'($urandom);
      bus.halt = 1'($urandom_range(0, 1));
      step();
      checks++; if (bus.cpu_wait !== bus.halt) begin errors++; $display("FAIL rnd_cpu_wait got %0h want %0h", bus.cpu_wait, bus.halt); end
      case (kind)
        0: test_cpu_read(addr, 6);
        1: test_cpu_write(addr, data);
        2: test_diag(1'b0, addr, data);
        default: test_diag(1'b1, addr, data);
      endcase
    end
    bus.halt = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int cs0;
    int acks;
    bus.diag_addr = 16'h0002;
    bus.diag_we = 1'b0;
    bus.diag_req = 1'b1;
    step();
    checks++; if (bus.ram_cs !== 1'b1) begin errors++; $display("FAIL rmid_in_access got %0h want 1", bus.ram_cs); end
    reset = 1'b1;
    bus.load_done = 1'b0;
    bus.diag_req = 1'b0;
    step();
    reset = 1'b0;
    exp_cpu_rdata = 8'h00;
    exp_rd_data = 8'h00;
    checks++; if (bus.ram_cs !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0000) begin errors++; $display("FAIL rmid_ram_port got cs=%0h we=%0h addr=%0h want 0", bus.ram_cs, bus.ram_we, bus.ram_addr); end
    checks++; if (bus.diag_ack !== 1'b0 || bus.cpu_wait !== 1'b1 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL rmid_status got ack=%0h wait=%0h rd=%0h want 0 1 0", bus.diag_ack, bus.cpu_wait, bus.rd_data); end
    // In LOAD, CPU and diag requests are ignored.
    cs0 = cs_count;
    acks = 0;
    bus.cpu_addr = 16'h0002;
    bus.cpu_we = 1'b0;
    bus.cpu_req = 1'b1;
    bus.diag_req = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      if (bus.diag_ack === 1'b1) acks++;
    end
    bus.cpu_req = 1'b0;
    bus.diag_req = 1'b0;
    checks++; if (acks != 0 || cs_count - cs0 != 0) begin errors++; $display("FAIL rmid_load_ignores got acks=%0d cycles=%0d want 0 0", acks, cs_count - cs0); end
    checks++; if (bus.cpu_wait !== 1'b1) begin errors++; $display("FAIL rmid_load_wait got %0h want 1", bus.cpu_wait); end
    step();
    bus.load_done = 1'b1;
    step();
    step();
    checks++; if (bus.cpu_wait !== 1'b0) begin errors++; $display("FAIL rmid_run_wait got %0h want 0", bus.cpu_wait); end
    test_cpu_read(16'h0002, 6);
  endtask

  initial begin
    reset = 1'b1;
    bus.load_done = 1'b0;
    bus.halt = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_wdata = 8'h00;
    bus.flash_req = 1'b0;
    bus.flash_we = 1'b0;
    bus.flash_addr = 16'h0000;
    bus.flash_wdata = 8'h00;
    bus.diag_req = 1'b0;
    bus.diag_we = 1'b0;
    bus.diag_addr = 16'h0000;
    bus.diag_wdata = 8'h00;
    exp_cpu_rdata = 8'h00;
    exp_rd_data = 8'h00;
    test_reset();
    test_boot();
    test_cpu_read(16'h0002, 20);
    test_cpu_write(16'h8000, 8'h55);
    test_cpu_write_cancel();
    test_cpu_read(16'h8000, 6);
    test_contention();
    test_halt();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
